sr_button_latch_driver: RTL
===========================

// Module: sr_button_latch_driver
// PURPOSE
//  Upstream stage for the SR latch: turns two raw, asynchronous push-button inputs
//  (set, reset) into clean single-cycle S/R pulses.
//  Also keeps a clocked latched state q/q_n, so the latch never sees S=R=1 or bounce.
//  Sits between the board buttons and the SR latch / latching-output logic.
//  Provides a conflict flag when both buttons qualify in the same cycle.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable synchronised samples needed to accept a new level (>=1)
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  localparam, width of each debounce counter
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  btn_set    in   1  raw set button, asynchronous, may bounce
//  btn_reset  in   1  raw reset button, asynchronous, may bounce
//  s_pulse    out  1  one-cycle set pulse to the latch S input
//  r_pulse    out  1  one-cycle reset pulse to the latch R input
//  q          out  1  latched state
//  q_n        out  1  always ~q (never equal to q, never X after reset)
//  conflict   out  1  one-cycle flag: both set and reset qualified on the same edge
// BEHAVIOUR
//  - Reset (sampled on clk edge with reset=1): sync FFs=0, debounced levels=0, counters=0,
//    s_pulse=r_pulse=conflict=0, q=0, q_n=1. Reset overrides all other activity, including
//    a debounce in progress or a pulse due on that edge. q/q_n are X only before the first reset.
//  - Per channel, identical and independent:
//    - 2-FF synchroniser.
//    - Debounce: counter increments while sync level != debounced level.
//      It clears to 0 on any cycle where they are equal.
//      When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
//    - Rise detect: rise = debounced 0->1 transition; exactly one cycle, no repeat while held.
//    - Release (1->0) produces no pulse.
//  - Latency: btn held stable high from edge k (first sampling edge) -> s_pulse/r_pulse high
//    during the cycle after edge k+2+DEBOUNCE_CYCLES. Any glitch shorter than
//    DEBOUNCE_CYCLES synced samples produces no pulse.
//  - Output stage (registered, same edge):
//    - set_rise & !reset_rise: s_pulse=1, q<=1.
//    - reset_rise & !set_rise: r_pulse=1, q<=0.
//    - Both rise on the same edge: s_pulse=r_pulse=0, q holds, conflict=1 for one cycle.
//    - Neither: pulses 0, q holds.
//    - A second set while q=1 still pulses s_pulse (q stays 1); likewise for reset.
//  - Invariant: s_pulse & r_pulse never both 1.
//  - Button held through reset release: the debounced level restarts at 0, so a pulse is
//    issued after the full latency (intended).
// STRUCTURE
//  - Package sr_latch_pkg:
//    - DEBOUNCE_CYCLES_DEFAULT constant.
//    - typedef enum logic [1:0] {SR_HOLD, SR_SET, SR_RESET, SR_CONFLICT} sr_cmd_t,
//      decoded from {set_rise, reset_rise}.
//  - Sub-module button_debounce (clk, reset, raw, level, rise): synchroniser + counter
//    + edge detect; instantiated twice. The top holds only the output/arbitration registers.
// TESTING (DEBOUNCE_CYCLES=4, latency 7 edges)
//  1. Reset with buttons low -> q=0, q_n=1, pulses=0, conflict=0.
//     Check q/q_n are not X, mirroring the latch's initial-state check.
//  2. btn_set high held -> s_pulse=1 for exactly one cycle 7 edges later; q=1, q_n=0;
//     no further pulse while held.
//  3. btn_set bounce 1,0,1,0 per cycle then low -> no s_pulse; q unchanged.
//  4. btn_reset held after step 2 -> r_pulse one cycle after 7 edges; q=0, q_n=1.
//  5. btn_set and btn_reset raised on the same edge, held -> conflict=1 one cycle;
//     s_pulse=r_pulse=0; q holds its previous value.
//  6. Assert reset 3 cycles into a set debounce, release with btn_set still high ->
//     q=0 during reset; s_pulse 7 edges after release; q=1.

Source files
------------

// File: rtl/sr_latch_pkg.sv
//==============================================================================
// Module  : sr_latch_pkg
// Brief   : Shared constants and command decode for the SR button latch driver.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

package sr_latch_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        SR_HOLD     = 2'd0,
        SR_SET      = 2'd1,
        SR_RESET    = 2'd2,
        SR_CONFLICT = 2'd3
    } sr_cmd_t;

    function automatic sr_cmd_t decode_cmd(input logic set_rise, input logic reset_rise);
        sr_cmd_t cmd;
        case ({set_rise, reset_rise})
            2'b10:   cmd = SR_SET;
            2'b01:   cmd = SR_RESET;
            2'b11:   cmd = SR_CONFLICT;
            default: cmd = SR_HOLD;
        endcase
        return cmd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
//==============================================================================
// Module  : button_debounce
// Brief   : 2-FF synchroniser, stable-sample debouncer and registered rise pulse.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module button_debounce
    import sr_latch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_lvl;
    logic [CNT_W-1:0] cnt;

    // Counting to DEBOUNCE_CYCLES-1 means the flip lands on the N-th mismatched sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_lvl  <= 1'b0;
            level     <= 1'b0;
            rise      <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= raw;
            sync_lvl  <= sync_meta;
            rise      <= 1'b0;
            if (sync_lvl == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_lvl;
                rise  <= sync_lvl;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sr_button_latch_driver.sv
//==============================================================================
// Module  : sr_button_latch_driver
// Brief   : Debounced set/reset buttons to clean S/R pulses with a clocked q/q_n.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module sr_button_latch_driver
    import sr_latch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_set,
    input  logic btn_reset,
    output logic s_pulse,
    output logic r_pulse,
    output logic q,
    output logic q_n,
    output logic conflict
);

    logic    set_rise;
    logic    reset_rise;
    sr_cmd_t cmd;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_set),
        .level (),
        .rise  (set_rise)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_db (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_reset),
        .level (),
        .rise  (reset_rise)
    );

    assign cmd = decode_cmd(set_rise, reset_rise);

    // Simultaneous set and reset is refused: q holds and only the conflict flag fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_pulse  <= 1'b0;
            r_pulse  <= 1'b0;
            conflict <= 1'b0;
            q        <= 1'b0;
        end else begin
            s_pulse  <= 1'b0;
            r_pulse  <= 1'b0;
            conflict <= 1'b0;
            case (cmd)
                SR_SET: begin
                    s_pulse <= 1'b1;
                    q       <= 1'b1;
                end
                SR_RESET: begin
                    r_pulse <= 1'b1;
                    q       <= 1'b0;
                end
                SR_CONFLICT: conflict <= 1'b1;
                default: ;
            endcase
        end
    end

    assign q_n = ~q;

endmodule

`default_nettype wire
